rbcp_reg_responder: RTL and testbench
=====================================

Name: rbcp_reg_responder

Overview:
- User-side responder for the SiTCP RBCP local bus. It decodes LOC_ADDR against a base window and services single-byte read and write requests.
- It holds a bank of RW control bytes, a snapshot-on-read 32-bit status word, a write-1-pulse command byte and an ID byte. It returns LOC_ACK and LOC_RD with a programmable latency.
- It sits between the SiTCP core's LOC_* initiator outputs and the user control logic.

Parameters:
- BASE_ADDR, 32'h0000_0000, window base; bits [31:5] of LOC_ADDR must equal BASE_ADDR[31:5].
- NUM_RW, 8, number of RW bytes (1..16) at offsets 0x00..NUM_RW-1.
- ACK_DELAY, 1, cycles from request strobe to LOC_ACK (1..15).
- ID_VALUE, 8'hA5, constant returned at offset 0x15.

Ports:
- CLK  in  1  system clock (SiTCP CLK domain)
- RSTn  in  1  reset, asynchronous, active-low
- LOC_ACT  in  1  RBCP transaction active
- LOC_ADDR  in  32  byte address, valid with LOC_WE/LOC_RE
- LOC_WD  in  8  write data, valid with LOC_WE
- LOC_WE  in  1  write strobe, 1-cycle pulse
- LOC_RE  in  1  read strobe, 1-cycle pulse
- LOC_ACK  out  1  access acknowledge, 1-cycle pulse
- LOC_RD  out  8  read data, valid only while LOC_ACK=1
- REG_OUT  out  8*NUM_RW  RW bytes; byte k is REG_OUT[8k+7:8k]
- STATUS_IN  in  32  user status word, sampled on snapshot
- CMD_PULSE  out  8  command pulses
- BUS_ERR  out  1  1-cycle pulse on an unmapped in-window access

Behaviour:
- Reset (RSTn=0, async): state IDLE; LOC_ACK=0, LOC_RD=0, REG_OUT=0, CMD_PULSE=0, BUS_ERR=0, snapshot=0, delay counter=0.
- Address map (offset = LOC_ADDR[4:0], only when the window matches):
  - 0x00..NUM_RW-1: RW bytes.
  - 0x10..0x13: snapshot bytes 0..3, LSB first; read-only, writes are acked and ignored.
  - 0x14: CMD; a write pulses CMD_PULSE=LOC_WD for exactly 1 cycle; reads return 0.
  - 0x15: ID, read-only.
  - All other offsets are unmapped.
- Out of window: the block ignores the request entirely: no ACK, no BUS_ERR, stays IDLE.
- States:
  - IDLE: on LOC_WE or LOC_RE with window match, latch addr, data and op, load counter=ACK_DELAY-1, go to WAIT. WE has priority when WE and RE are asserted in the same cycle (treated as a write).
  - WAIT: decrement the counter; when the counter is 0, go to ACK. LOC_ACT=0 in WAIT: abort to IDLE, with no ACK, no register update and no pulse.
  - ACK: assert LOC_ACK for 1 cycle, then go to IDLE.
- ACK latency: with ACK_DELAY=1, LOC_ACK is high in the cycle exactly 1 after the strobe. In general LOC_ACK rises ACK_DELAY cycles after the strobe.
- Side effects in the ACK cycle:
  - Mapped write: the RW byte updates in the ACK cycle and is visible on REG_OUT the next cycle.
  - Mapped read: LOC_RD carries the data in the ACK cycle and is 0 in all other cycles.
  - Unmapped access: LOC_ACK stays 0 and BUS_ERR pulses in the cycle LOC_ACK would have been asserted. SiTCP then times out and reports a bus error to the host.
- Snapshot: the read of offset 0x10 loads snapshot <= STATUS_IN at request latch and returns STATUS_IN[7:0]. Offsets 0x11..0x13 return snapshot bytes without resampling, so a 4-byte burst is coherent.
- Strobes arriving while in WAIT or ACK are ignored.
- Aborted transactions leave snapshot as already loaded.
- LOC_ADDR bits [4:0] above 0x15 are unmapped; there is no wrap-around.

Test Plan:
- Write 0x3C to offset 0x02 (ACK_DELAY=1) -> LOC_ACK high exactly 1 cycle after LOC_WE; REG_OUT[23:16]=0x3C on the following cycle; other bytes 0.
- Read offset 0x02 after the write above -> LOC_RD=0x3C with LOC_ACK; LOC_RD=0 in the cycles before and after.
- Set STATUS_IN=0x11223344 and read 0x10; change STATUS_IN to 0xDEADBEEF; read 0x11..0x13 -> returns 0x44, 0x33, 0x22, 0x11.
- Write 0x81 to 0x14 -> CMD_PULSE=0x81 for 1 cycle then 0; read 0x14 -> 0x00; read 0x15 -> 0xA5.
- Access offset 0x1F in window -> no LOC_ACK, BUS_ERR pulses 1 cycle. Access with LOC_ADDR[31:5] mismatched -> no ACK, no BUS_ERR.
- ACK_DELAY=4: drop LOC_ACT 2 cycles into a write of 0x55 to 0x00 -> no ACK, REG_OUT[7:0] unchanged. Assert RSTn=0 mid-WAIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/rbcp_reg_responder_if.sv
// rbcp_reg_responder_if: SiTCP RBCP local-bus signals between the initiator core and the user-side responder.
interface rbcp_reg_responder_if;
  logic        loc_act;
  logic [31:0] loc_addr;
  logic [7:0]  loc_wd;
  logic        loc_we;
  logic        loc_re;
  logic        loc_ack;
  logic [7:0]  loc_rd;
  modport master (output loc_act, loc_addr, loc_wd, loc_we, loc_re, input loc_ack, loc_rd);
  modport slave (input loc_act, loc_addr, loc_wd, loc_we, loc_re, output loc_ack, loc_rd);
endinterface

// File: rtl/rbcp_reg_responder.sv
// rbcp_reg_responder: RBCP register responder with RW bytes, coherent status snapshot, command pulses and ID.
module rbcp_reg_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_RW    = 8,
  parameter int          ACK_DELAY = 1,
  parameter logic [7:0]  ID_VALUE  = 8'hA5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  rbcp_reg_responder_if.slave   bus,
  input  logic [31:0]           status_i,
  output logic [8*NUM_RW-1:0]   reg_o,
  output logic [7:0]            cmd_pulse_o,
  output logic                  bus_err_o
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;
  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [4:0]          off_q, off_d;
  logic                we_q, we_d;
  logic [7:0]          wd_q, wd_d;
  logic [31:0]         snap_q, snap_d;
  logic [8*NUM_RW-1:0] reg_q;
  logic [7:0]          rd_q, cmd_q, rd_val;
  logic                ack_q, err_q;
  logic                lat, rw_hit, mapped, go_ack;
  logic [127:0]        rw_pad;
  // The *_d values fold the request being latched this cycle in, so a one-cycle latency still gets registered outputs.
  always_comb begin
    lat    = state_q == IDLE && (bus.loc_we || bus.loc_re) && bus.loc_addr[31:5] == BASE_ADDR[31:5];
    off_d  = lat ? bus.loc_addr[4:0] : off_q;
    we_d   = lat ? bus.loc_we : we_q;
    wd_d   = lat ? bus.loc_wd : wd_q;
    snap_d = lat && !bus.loc_we && bus.loc_addr[4:0] == 5'h10 ? status_i : snap_q;
    rw_hit = int'(off_d) < NUM_RW;
    mapped = rw_hit || (off_d >= 5'h10 && off_d <= 5'h15);
    rw_pad = 128'(reg_q);
    rd_val = rw_hit ? rw_pad[{off_d[3:0], 3'b000} +: 8] :
             off_d[4:2] == 3'b100 ? snap_d[{off_d[1:0], 3'b000} +: 8] :
             off_d == 5'h15 ? ID_VALUE : 8'h00;
    go_ack = (lat && ACK_DELAY == 1) || (state_q == WAIT && bus.loc_act && cnt_q == 4'd1);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      snap_q  <= '0;
      reg_q   <= '0;
      rd_q    <= '0;
      cmd_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      off_q  <= off_d;
      we_q   <= we_d;
      wd_q   <= wd_d;
      snap_q <= snap_d;
      ack_q  <= go_ack && mapped;
      err_q  <= go_ack && !mapped;
      rd_q   <= go_ack && mapped && !we_d ? rd_val : 8'h00;
      cmd_q  <= go_ack && we_d && off_d == 5'h14 ? wd_d : 8'h00;
      case (state_q)
        IDLE: if (lat) begin
          state_q <= ACK_DELAY == 1 ? ACK : WAIT;
          cnt_q   <= 4'(ACK_DELAY - 1);
        end
        WAIT: if (!bus.loc_act) state_q <= IDLE;
        else begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= ACK;
        end
        default: begin
          state_q <= IDLE;
          for (int k = 0; k < NUM_RW; k++)
            if (we_q && int'(off_q) == k) reg_q[8*k +: 8] <= wd_q;
        end
      endcase
    end
  end
  assign bus.loc_ack = ack_q;
  assign bus.loc_rd  = rd_q;
  assign reg_o       = reg_q;
  assign cmd_pulse_o = cmd_q;
  assign bus_err_o   = err_q;
endmodule

// File: tb/tb_rbcp_reg_responder.sv
// tb_rbcp_reg_responder: directed vector table on a 1-cycle-latency instance plus abort/reset sequences on a 4-cycle one.
module tb_rbcp_reg_responder;
  logic clk = 1'b0, rst_na = 1'b0, rst_nb = 1'b0;
  logic [31:0] st_a = '0, st_b = '0;
  logic [63:0] reg_a, reg_b;
  logic [7:0] cmd_a, cmd_b;
  logic err_a, err_b;
  int total = 0, bad = 0;
  rbcp_reg_responder_if ia();
  rbcp_reg_responder_if ib();
  rbcp_reg_responder #(.ACK_DELAY(1)) dut_a (.clk_i(clk), .rst_ni(rst_na), .bus(ia.slave), .status_i(st_a),
    .reg_o(reg_a), .cmd_pulse_o(cmd_a), .bus_err_o(err_a));
  rbcp_reg_responder #(.ACK_DELAY(4)) dut_b (.clk_i(clk), .rst_ni(rst_nb), .bus(ib.slave), .status_i(st_b),
    .reg_o(reg_b), .cmd_pulse_o(cmd_b), .bus_err_o(err_b));
  always #5 clk = ~clk;
  typedef struct {
    bit we; bit re; logic [31:0] addr; logic [7:0] wd; logic [31:0] st;
    int ack_at; logic [7:0] rd; bit err; logic [7:0] cmd; logic [63:0] regv;
  } vec_t;
  vec_t v[18];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic op_a(input bit we, input bit re, input logic [31:0] addr, input logic [7:0] wd,
                      output int ack_at, output logic [7:0] rd, output bit err, output logic [7:0] cmd,
                      output int cmd_n, output int leak);
    ack_at = 0; rd = '0; err = 0; cmd = '0; cmd_n = 0; leak = 0;
    @(negedge clk);
    if (ia.loc_rd !== 8'h00) leak++;
    ia.loc_we = we; ia.loc_re = re; ia.loc_addr = addr; ia.loc_wd = wd;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      ia.loc_we = 1'b0; ia.loc_re = 1'b0;
      if (ia.loc_ack) begin ack_at = i; rd = ia.loc_rd; end
      else if (ia.loc_rd !== 8'h00) leak++;
      if (err_a) err = 1;
      if (cmd_a !== 8'h00) begin cmd = cmd_a; cmd_n++; end
    end
  endtask
  task automatic op_b(input logic [4:0] off, input logic [7:0] wd, input int drop, output int ack_at, output bit err);
    ack_at = 0; err = 0;
    @(negedge clk);
    ib.loc_act = 1'b1; ib.loc_we = 1'b1; ib.loc_addr = {27'b0, off}; ib.loc_wd = wd;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      ib.loc_we = 1'b0;
      if (i == drop) ib.loc_act = 1'b0;
      if (ib.loc_ack && ack_at == 0) ack_at = i;
      if (err_b) err = 1;
    end
    ib.loc_act = 1'b1;
  endtask
  initial begin
    int ack_at, cmd_n, leak, hits;
    logic [7:0] rd, cmd;
    bit err;
    v = '{
      '{1, 0, 32'h02, 8'h3C, 32'h0,        1, 8'h00, 0, 8'h00, 64'h0000_0000_003C_0000},
      '{0, 1, 32'h02, 8'h00, 32'h0,        1, 8'h3C, 0, 8'h00, 64'h0000_0000_003C_0000},
      '{0, 1, 32'h10, 8'h00, 32'h11223344, 1, 8'h44, 0, 8'h00, 64'h0000_0000_003C_0000},
      '{0, 1, 32'h11, 8'h00, 32'hDEADBEEF, 1, 8'h33, 0, 8'h00, 64'h0000_0000_003C_0000},
      '{0, 1, 32'h12, 8'h00, 32'hDEADBEEF, 1, 8'h22, 0, 8'h00, 64'h0000_0000_003C_0000},
      '{0, 1, 32'h13, 8'h00, 32'hDEADBEEF, 1, 8'h11, 0, 8'h00, 64'h0000_0000_003C_0000},
      '{1, 0, 32'h14, 8'h81, 32'hDEADBEEF, 1, 8'h00, 0, 8'h81, 64'h0000_0000_003C_0000},
      '{0, 1, 32'h14, 8'h00, 32'hDEADBEEF, 1, 8'h00, 0, 8'h00, 64'h0000_0000_003C_0000},
      '{0, 1, 32'h15, 8'h00, 32'hDEADBEEF, 1, 8'hA5, 0, 8'h00, 64'h0000_0000_003C_0000},
      '{0, 1, 32'h1F, 8'h00, 32'hDEADBEEF, 0, 8'h00, 1, 8'h00, 64'h0000_0000_003C_0000},
      '{1, 0, 32'h16, 8'hFF, 32'hDEADBEEF, 0, 8'h00, 1, 8'h00, 64'h0000_0000_003C_0000},
      '{1, 0, 32'h22, 8'hEE, 32'hDEADBEEF, 0, 8'h00, 0, 8'h00, 64'h0000_0000_003C_0000},
      '{1, 0, 32'h10, 8'hAB, 32'hDEADBEEF, 1, 8'h00, 0, 8'h00, 64'h0000_0000_003C_0000},
      '{0, 1, 32'h10, 8'h00, 32'hDEADBEEF, 1, 8'hEF, 0, 8'h00, 64'h0000_0000_003C_0000},
      '{1, 0, 32'h07, 8'h99, 32'hDEADBEEF, 1, 8'h00, 0, 8'h00, 64'h9900_0000_003C_0000},
      '{0, 1, 32'h08, 8'h00, 32'hDEADBEEF, 0, 8'h00, 1, 8'h00, 64'h9900_0000_003C_0000},
      '{1, 1, 32'h01, 8'h42, 32'hDEADBEEF, 1, 8'h00, 0, 8'h00, 64'h9900_0000_003C_4200},
      '{0, 1, 32'h01, 8'h00, 32'hDEADBEEF, 1, 8'h42, 0, 8'h00, 64'h9900_0000_003C_4200}
    };
    ia.loc_act = 1'b1; ia.loc_we = 1'b0; ia.loc_re = 1'b0; ia.loc_addr = '0; ia.loc_wd = '0;
    ib.loc_act = 1'b1; ib.loc_we = 1'b0; ib.loc_re = 1'b0; ib.loc_addr = '0; ib.loc_wd = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 64'(ia.loc_ack), 64'h0);
    chk("rst_rd", 64'(ia.loc_rd), 64'h0);
    chk("rst_reg", reg_a, 64'h0);
    chk("rst_cmd", 64'(cmd_a), 64'h0);
    chk("rst_err", 64'(err_a), 64'h0);
    rst_na = 1'b1; rst_nb = 1'b1;
    for (int i = 0; i < 18; i++) begin
      st_a = v[i].st;
      op_a(v[i].we, v[i].re, v[i].addr, v[i].wd, ack_at, rd, err, cmd, cmd_n, leak);
      chk($sformatf("v%0d_ack_at", i), 64'(ack_at), 64'(v[i].ack_at));
      chk($sformatf("v%0d_rd", i), 64'(rd), 64'(v[i].rd));
      chk($sformatf("v%0d_err", i), 64'(err), 64'(v[i].err));
      chk($sformatf("v%0d_cmd", i), 64'(cmd), 64'(v[i].cmd));
      chk($sformatf("v%0d_cmd_width", i), 64'(cmd_n), v[i].cmd != 8'h00 ? 64'h1 : 64'h0);
      chk($sformatf("v%0d_rd_leak", i), 64'(leak), 64'h0);
      chk($sformatf("v%0d_reg", i), reg_a, v[i].regv);
    end
    // Write lands on reg_o only the cycle after the ACK cycle.
    @(negedge clk);
    ia.loc_we = 1'b1; ia.loc_addr = 32'h03; ia.loc_wd = 8'h5A;
    @(negedge clk);
    ia.loc_we = 1'b0;
    chk("wr_ack_cycle_ack", 64'(ia.loc_ack), 64'h1);
    chk("wr_ack_cycle_reg", 64'(reg_a[31:24]), 64'h00);
    @(negedge clk);
    chk("wr_next_ack", 64'(ia.loc_ack), 64'h0);
    chk("wr_next_reg", 64'(reg_a[31:24]), 64'h5A);
    op_b(5'h00, 8'h77, 0, ack_at, err);
    chk("b_wr_ack_at", 64'(ack_at), 64'd4);
    chk("b_wr_err", 64'(err), 64'h0);
    chk("b_wr_reg", 64'(reg_b[7:0]), 64'h77);
    op_b(5'h00, 8'h55, 2, ack_at, err);
    chk("b_abort_ack", 64'(ack_at), 64'h0);
    chk("b_abort_err", 64'(err), 64'h0);
    chk("b_abort_reg", 64'(reg_b[7:0]), 64'h77);
    @(negedge clk);
    ib.loc_we = 1'b1; ib.loc_addr = 32'h01; ib.loc_wd = 8'h12;
    @(negedge clk);
    ib.loc_we = 1'b0;
    @(negedge clk);
    #2 rst_nb = 1'b0;
    #1;
    chk("b_rst_reg", reg_b, 64'h0);
    chk("b_rst_ack", 64'(ib.loc_ack), 64'h0);
    chk("b_rst_rd", 64'(ib.loc_rd), 64'h0);
    chk("b_rst_cmd", 64'(cmd_b), 64'h0);
    chk("b_rst_err", 64'(err_b), 64'h0);
    @(negedge clk);
    rst_nb = 1'b1;
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (ib.loc_ack || err_b) hits++;
    end
    chk("b_post_rst_quiet", 64'(hits), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
